mem_bus_arbiter: RTL and testbench
==================================

Name: mem_bus_arbiter

Overview:
- Shares the single memory bus between two masters: port 0 (CPU load/store unit) and port 1 (DMA / debug master).
- Each master issues a one-cycle DV request: bhw, address, data, write_notread.
- The arbiter buffers one pending request per port, grants round-robin, and forwards the request to memory as a one-cycle DV pulse.
- It routes the memory's DV response back to the owning port, with a watchdog timeout on unresponsive memory.

Parameters:
- TIMEOUT_CYCLES, 1024: WAIT-state cycles before a transaction is aborted (must be ≥2).
- TIMEOUT_DATA, 32'hDEAD_BEEF: response data returned on timeout.

Ports:
- i_clk  in  1  clock, all logic on posedge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_pN_DV  in  1  request strobe, one cycle (N = 0,1; same set per port below).
- i_pN_bhw  in  3  access size: 001 byte, 010 half, 100 word.
- i_pN_address  in  32  byte address.
- i_pN_data  in  32  write data.
- i_pN_write_notread  in  1  1 = write, 0 = read.
- o_pN_resp_data  out  32  read data, or TIMEOUT_DATA on timeout.
- o_pN_resp_DV  out  1  one-cycle completion pulse (also pulses for writes).
- o_pN_overflow  out  1  one-cycle pulse: request dropped because the slot was occupied.
- o_mem_bhw  out  3  forwarded size.
- o_mem_address  out  32  forwarded address.
- o_mem_data  out  32  forwarded write data.
- o_mem_write_notread  out  1  forwarded direction.
- o_mem_DV  out  1  one-cycle request strobe to memory.
- i_mem_DV  in  1  memory completion strobe.
- i_mem_data  in  32  memory read data.
- o_busy  out  1  high while in WAIT.
- o_timeout  out  1  one-cycle pulse on watchdog abort.

Behaviour:
- Reset (async assert, sync-released):
  - All outputs 0.
  - Pending slots empty; state IDLE; timer 0.
  - Round-robin pointer favours port 0.
  - Reset mid-transaction abandons it; no response is generated, and a later i_mem_DV is ignored.
- DV outputs (o_mem_DV, o_pN_resp_DV, o_pN_overflow, o_timeout) default to 0 every cycle; they are only ever single-cycle pulses.
- Capture:
  - i_pN_DV at edge k, with slot N empty or being granted at edge k: fields latched, slot N valid.
  - Set has priority over the clear caused by the grant.
  - If slot N is valid and not granted at edge k: request dropped, o_pN_overflow pulses, slot unchanged.
- States:
  - IDLE → WAIT:
    - Trigger: at least one slot valid.
    - Winner: the only valid port; if both are valid, the port not granted last.
    - Action: drive o_mem_* from the winner's slot, o_mem_DV=1, clear the slot, record owner, timer=0, o_busy=1.
  - WAIT → IDLE (response):
    - Trigger: i_mem_DV=1.
    - Action: o_owner_resp_data <= i_mem_data, o_owner_resp_DV=1, pointer <= owner, o_busy=0.
  - WAIT → IDLE (timeout):
    - Trigger: timer == TIMEOUT_CYCLES-1 with i_mem_DV=0.
    - Action: o_owner_resp_data <= TIMEOUT_DATA, o_owner_resp_DV=1, o_timeout=1, pointer <= owner.
  - WAIT, otherwise: timer+1. o_mem_* fields hold; o_mem_DV stays 0.
- Latency and throughput:
  - Minimum 2 edges from request to memory: request at edge k gives o_mem_DV high after edge k+1.
  - Response is 1 edge after i_mem_DV.
  - No back-to-back overlap: the next grant is at the earliest one edge after returning to IDLE.
- i_mem_DV in IDLE: ignored, no response pulse.
- i_mem_DV on the same edge as the timeout threshold: treated as a normal response; no o_timeout.
- o_pN_resp_data holds its last value between pulses.
- Width rule: bhw, address and data are forwarded unmodified; no sign-extension or masking (that is the requester's job).

Test Plan:
- Single read:
  - Stimulus: p0 DV, bhw=100, addr=0x100; memory answers 0x12345678 three cycles after o_mem_DV.
  - Expect: o_mem_DV pulses 2 edges after the request, address 0x100, write_notread=0; o_p0_resp_DV pulses once with 0x12345678; o_busy spans the wait.
- Simultaneous requests:
  - Stimulus: p0 (read 0x10) and p1 (write 0x20, data 0xAA) on the same cycle, after reset.
  - Expect: p0 granted first; p1 issued after p0's response. A second simultaneous pair grants p1 first.
- Overflow:
  - Stimulus: p1 issues two DVs while p0 owns the bus.
  - Expect: o_p1_overflow pulses on the second; the first request is serviced later with its original fields.
- Timeout (TIMEOUT_CYCLES=8):
  - Stimulus: memory never responds to a p1 read.
  - Expect: exactly 8 WAIT cycles, then o_p1_resp_DV with 0xDEADBEEF and o_timeout; a late i_mem_DV produces no response.
- Boundary:
  - i_mem_DV exactly at cycle 8 returns memory data, no o_timeout.
  - A p0 request arriving on the edge its previous slot is granted is retained and issued next.
- Reset mid-WAIT:
  - Stimulus: assert i_rst_n=0 asynchronously.
  - Expect: outputs 0 immediately; no response pulse after release; the next p1 request is granted normally.

Source files
------------

// File: rtl/mem_bus_arbiter_if.sv
// Bundle of the two requester ports and the memory-side bus shared by mem_bus_arbiter.
// The slave modport is the arbiter's view; master is the environment (requesters plus memory).
interface mem_bus_arbiter_if;
    logic        i_p0_DV;
    logic [2:0]  i_p0_bhw;
    logic [31:0] i_p0_address;
    logic [31:0] i_p0_data;
    logic        i_p0_write_notread;
    logic [31:0] o_p0_resp_data;
    logic        o_p0_resp_DV;
    logic        o_p0_overflow;

    logic        i_p1_DV;
    logic [2:0]  i_p1_bhw;
    logic [31:0] i_p1_address;
    logic [31:0] i_p1_data;
    logic        i_p1_write_notread;
    logic [31:0] o_p1_resp_data;
    logic        o_p1_resp_DV;
    logic        o_p1_overflow;

    logic [2:0]  o_mem_bhw;
    logic [31:0] o_mem_address;
    logic [31:0] o_mem_data;
    logic        o_mem_write_notread;
    logic        o_mem_DV;
    logic        i_mem_DV;
    logic [31:0] i_mem_data;

    // All strobes (*_DV) are single-cycle pulses; there is no ready/backpressure,
    // a request arriving at an occupied slot is dropped and flagged by o_pN_overflow.
    modport slave (
        input  i_p0_DV, i_p0_bhw, i_p0_address, i_p0_data, i_p0_write_notread,
        output o_p0_resp_data, o_p0_resp_DV, o_p0_overflow,
        input  i_p1_DV, i_p1_bhw, i_p1_address, i_p1_data, i_p1_write_notread,
        output o_p1_resp_data, o_p1_resp_DV, o_p1_overflow,
        output o_mem_bhw, o_mem_address, o_mem_data, o_mem_write_notread, o_mem_DV,
        input  i_mem_DV, i_mem_data
    );

    modport master (
        output i_p0_DV, i_p0_bhw, i_p0_address, i_p0_data, i_p0_write_notread,
        input  o_p0_resp_data, o_p0_resp_DV, o_p0_overflow,
        output i_p1_DV, i_p1_bhw, i_p1_address, i_p1_data, i_p1_write_notread,
        input  o_p1_resp_data, o_p1_resp_DV, o_p1_overflow,
        input  o_mem_bhw, o_mem_address, o_mem_data, o_mem_write_notread, o_mem_DV,
        output i_mem_DV, i_mem_data
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Two-port round-robin arbiter for a single memory bus: one buffered request per port,
// one outstanding memory transaction, watchdog abort when memory never answers.
module mem_bus_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter logic [31:0] TIMEOUT_DATA   = 32'hDEAD_BEEF
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    mem_bus_arbiter_if.slave bus,
    output logic             o_busy,
    output logic             o_timeout,
    output logic             state_dbg
);
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

    typedef struct packed {
        logic [2:0]  bhw;
        logic [31:0] address;
        logic [31:0] data;
        logic        write_notread;
    } req_t;

    state_t        state, state_next;
    req_t          in_req [2];
    logic [1:0]    in_dv;
    req_t          slot [2];
    logic [1:0]    slot_valid;
    logic          owner;
    logic          last_grant;
    logic [TW-1:0] timer;

    logic          grant, winner, resp_hit, timeout_hit;
    logic [1:0]    take;

    req_t          mem_q;
    logic          mem_dv_q, timeout_q;
    logic [1:0]    resp_dv_q, overflow_q;
    logic [31:0]   resp_data_q [2];

    assign in_dv     = {bus.i_p1_DV, bus.i_p0_DV};
    assign in_req[0] = {bus.i_p0_bhw, bus.i_p0_address, bus.i_p0_data, bus.i_p0_write_notread};
    assign in_req[1] = {bus.i_p1_bhw, bus.i_p1_address, bus.i_p1_data, bus.i_p1_write_notread};

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= S_IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (|slot_valid) state_next = S_WAIT;
            S_WAIT:  if (bus.i_mem_DV || timer == TIMER_LAST) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Decisions for the current edge; a response on the threshold cycle wins over the watchdog.
    always_comb begin
        grant       = 1'b0;
        winner      = 1'b0;
        resp_hit    = 1'b0;
        timeout_hit = 1'b0;
        case (state)
            S_IDLE: begin
                grant  = |slot_valid;
                winner = (&slot_valid) ? ~last_grant : slot_valid[1];
            end
            S_WAIT: begin
                resp_hit    = bus.i_mem_DV;
                timeout_hit = !bus.i_mem_DV && (timer == TIMER_LAST);
            end
            default: ;
        endcase
        take = grant ? (winner ? 2'b10 : 2'b01) : 2'b00;
    end

    // A new request may refill a slot on the same edge the slot is handed to memory.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            slot_valid <= '0;
            overflow_q <= '0;
            for (int p = 0; p < 2; p++) slot[p] <= '0;
        end else begin
            for (int p = 0; p < 2; p++) begin
                overflow_q[p] <= in_dv[p] && slot_valid[p] && !take[p];
                if (in_dv[p] && (!slot_valid[p] || take[p])) begin
                    slot[p]       <= in_req[p];
                    slot_valid[p] <= 1'b1;
                end else if (take[p]) begin
                    slot_valid[p] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            mem_q          <= '0;
            mem_dv_q       <= 1'b0;
            owner          <= 1'b0;
            last_grant     <= 1'b1;
            timer          <= '0;
            resp_dv_q      <= '0;
            resp_data_q[0] <= '0;
            resp_data_q[1] <= '0;
            timeout_q      <= 1'b0;
        end else begin
            mem_dv_q  <= grant;
            timeout_q <= timeout_hit;
            resp_dv_q <= '0;
            if (grant) begin
                mem_q <= slot[winner];
                owner <= winner;
                timer <= '0;
            end else if (state == S_WAIT) begin
                timer <= timer + TW'(1);
            end
            if (resp_hit || timeout_hit) begin
                resp_dv_q[owner]   <= 1'b1;
                resp_data_q[owner] <= resp_hit ? bus.i_mem_data : TIMEOUT_DATA;
                last_grant         <= owner;
            end
        end
    end

    assign bus.o_mem_bhw           = mem_q.bhw;
    assign bus.o_mem_address       = mem_q.address;
    assign bus.o_mem_data          = mem_q.data;
    assign bus.o_mem_write_notread = mem_q.write_notread;
    assign bus.o_mem_DV            = mem_dv_q;
    assign bus.o_p0_resp_DV        = resp_dv_q[0];
    assign bus.o_p1_resp_DV        = resp_dv_q[1];
    assign bus.o_p0_resp_data      = resp_data_q[0];
    assign bus.o_p1_resp_data      = resp_data_q[1];
    assign bus.o_p0_overflow       = overflow_q[0];
    assign bus.o_p1_overflow       = overflow_q[1];
    assign o_busy                  = (state == S_WAIT);
    assign o_timeout               = timeout_q;
    assign state_dbg               = state;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed scenarios plus a randomized run against a transaction-level model of the arbiter.
module tb_mem_bus_arbiter;
    localparam int TO = 8;

    typedef struct packed {
        logic [2:0]  bhw;
        logic [31:0] address;
        logic [31:0] data;
        logic        wr;
    } req_t;

    logic clk;
    logic rst_n;
    logic busy, timeout, state_dbg;
    int   n_checks = 0;
    int   n_fail   = 0;

    mem_bus_arbiter_if bus ();

    mem_bus_arbiter #(.TIMEOUT_CYCLES(TO), .TIMEOUT_DATA(32'hDEAD_BEEF)) dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .bus       (bus),
        .o_busy    (busy),
        .o_timeout (timeout),
        .state_dbg (state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic req_t mk(input logic [2:0] bhw, input logic [31:0] a, input logic [31:0] d, input logic wr);
        return {bhw, a, d, wr};
    endfunction

    function automatic req_t mem_obs();
        return {bus.o_mem_bhw, bus.o_mem_address, bus.o_mem_data, bus.o_mem_write_notread};
    endfunction

    task automatic step();
        @(negedge clk);
    endtask

    task automatic set_req(input int p, input req_t r);
        if (p == 0) begin
            bus.i_p0_DV = 1'b1; bus.i_p0_bhw = r.bhw; bus.i_p0_address = r.address;
            bus.i_p0_data = r.data; bus.i_p0_write_notread = r.wr;
        end else begin
            bus.i_p1_DV = 1'b1; bus.i_p1_bhw = r.bhw; bus.i_p1_address = r.address;
            bus.i_p1_data = r.data; bus.i_p1_write_notread = r.wr;
        end
    endtask

    task automatic set_mem(input logic [31:0] d);
        bus.i_mem_DV   = 1'b1;
        bus.i_mem_data = d;
    endtask

    task automatic clear_inputs();
        bus.i_p0_DV  = 1'b0;
        bus.i_p1_DV  = 1'b0;
        bus.i_mem_DV = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        clear_inputs();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        clear_inputs();
        set_req(0, '0); set_req(1, '0); clear_inputs();
        bus.i_mem_data = '0;
        #1 rst_n = 1'b0;
        #2;
        n_checks++;
        if ({bus.o_mem_DV, mem_obs(), bus.o_p0_resp_DV, bus.o_p1_resp_DV, bus.o_p0_resp_data,
             bus.o_p1_resp_data, bus.o_p0_overflow, bus.o_p1_overflow, busy, timeout, state_dbg} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got mem_dv=%b busy=%b to=%b st=%b, expected all zero",
                     bus.o_mem_DV, busy, timeout, state_dbg);
        end
        @(negedge clk); rst_n = 1'b1;
        step();
        n_checks++;
        if ({bus.o_mem_DV, busy} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_idle: got mem_dv=%b busy=%b expected 0 0", bus.o_mem_DV, busy);
        end
    endtask

    task automatic test_single_read();
        do_reset();
        set_req(0, mk(3'b100, 32'h100, 32'h0, 1'b0));
        step(); clear_inputs();
        n_checks++;
        if ({bus.o_mem_DV, busy} !== 2'b00) begin
            n_fail++; $display("FAIL single_early: got mem_dv=%b busy=%b expected 0 0", bus.o_mem_DV, busy);
        end
        step();
        n_checks++;
        if ({bus.o_mem_DV, busy, mem_obs()} !== {2'b11, mk(3'b100, 32'h100, 32'h0, 1'b0)}) begin
            n_fail++; $display("FAIL single_issue: got dv=%b busy=%b req=%h", bus.o_mem_DV, busy, mem_obs());
        end
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++;
            if ({bus.o_mem_DV, busy, bus.o_p0_resp_DV} !== 3'b010) begin
                n_fail++; $display("FAIL single_wait%0d: got dv=%b busy=%b resp=%b expected 0 1 0", i, bus.o_mem_DV, busy, bus.o_p0_resp_DV);
            end
        end
        set_mem(32'h1234_5678);
        step(); clear_inputs();
        n_checks++;
        if ({bus.o_p0_resp_DV, bus.o_p1_resp_DV, busy, bus.o_p0_resp_data} !== {3'b100, 32'h1234_5678}) begin
            n_fail++; $display("FAIL single_resp: got dv=%b/%b busy=%b data=%h expected 1/0 0 12345678",
                               bus.o_p0_resp_DV, bus.o_p1_resp_DV, busy, bus.o_p0_resp_data);
        end
        step();
        n_checks++;
        if ({bus.o_p0_resp_DV, bus.o_p0_resp_data} !== {1'b0, 32'h1234_5678}) begin
            n_fail++; $display("FAIL single_hold: got dv=%b data=%h expected 0 12345678", bus.o_p0_resp_DV, bus.o_p0_resp_data);
        end
    endtask

    // Issues the memory response for the owner and checks the response pulse on port p.
    task automatic answer(input int p, input logic [31:0] d, input string name);
        logic rdv;
        logic [31:0] rdata;
        set_mem(d);
        step(); clear_inputs();
        rdv   = (p == 0) ? bus.o_p0_resp_DV : bus.o_p1_resp_DV;
        rdata = (p == 0) ? bus.o_p0_resp_data : bus.o_p1_resp_data;
        n_checks++;
        if ({rdv, rdata, bus.o_mem_DV} !== {1'b1, d, 1'b0}) begin
            n_fail++; $display("FAIL %s: port%0d got dv=%b data=%h mem_dv=%b expected 1 %h 0", name, p, rdv, rdata, bus.o_mem_DV, d);
        end
    endtask

    task automatic check_issue(input req_t exp, input string name);
        n_checks++;
        if ({bus.o_mem_DV, mem_obs()} !== {1'b1, exp}) begin
            n_fail++; $display("FAIL %s: got dv=%b req=%h expected 1 %h", name, bus.o_mem_DV, mem_obs(), exp);
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        set_req(0, mk(3'b100, 32'h10, 32'h0, 1'b0));
        set_req(1, mk(3'b100, 32'h20, 32'hAA, 1'b1));
        step(); clear_inputs(); step();
        check_issue(mk(3'b100, 32'h10, 32'h0, 1'b0), "sim_first_p0");
        answer(0, 32'h0B0B_0B0B, "sim_resp_p0");
        step();
        check_issue(mk(3'b100, 32'h20, 32'hAA, 1'b1), "sim_then_p1");
        answer(1, 32'h0, "sim_resp_p1");
        // Port 0 is served alone so that port 1 becomes the favoured side for the next pair.
        set_req(0, mk(3'b001, 32'h30, 32'h0, 1'b0));
        step(); clear_inputs(); step();
        check_issue(mk(3'b001, 32'h30, 32'h0, 1'b0), "sim_solo_p0");
        answer(0, 32'h3333_3333, "sim_resp_solo");
        set_req(0, mk(3'b100, 32'h40, 32'h0, 1'b0));
        set_req(1, mk(3'b010, 32'h50, 32'hBB, 1'b1));
        step(); clear_inputs(); step();
        check_issue(mk(3'b010, 32'h50, 32'hBB, 1'b1), "sim2_first_p1");
        answer(1, 32'h5555_5555, "sim2_resp_p1");
        step();
        check_issue(mk(3'b100, 32'h40, 32'h0, 1'b0), "sim2_then_p0");
        answer(0, 32'h4444_4444, "sim2_resp_p0");
    endtask

    task automatic test_overflow();
        do_reset();
        set_req(0, mk(3'b100, 32'h200, 32'h0, 1'b0));
        step(); clear_inputs(); step();
        check_issue(mk(3'b100, 32'h200, 32'h0, 1'b0), "ovf_p0_issue");
        set_req(1, mk(3'b010, 32'h300, 32'h1111, 1'b1));
        step(); clear_inputs();
        n_checks++;
        if (bus.o_p1_overflow !== 1'b0) begin
            n_fail++; $display("FAIL ovf_first: got %b expected 0", bus.o_p1_overflow);
        end
        set_req(1, mk(3'b001, 32'h400, 32'h2222, 1'b0));
        step(); clear_inputs();
        n_checks++;
        if ({bus.o_p1_overflow, bus.o_p0_overflow} !== 2'b10) begin
            n_fail++; $display("FAIL ovf_second: got p1=%b p0=%b expected 1 0", bus.o_p1_overflow, bus.o_p0_overflow);
        end
        step();
        n_checks++;
        if (bus.o_p1_overflow !== 1'b0) begin
            n_fail++; $display("FAIL ovf_pulse: got %b expected 0", bus.o_p1_overflow);
        end
        answer(0, 32'h2020_2020, "ovf_resp_p0");
        step();
        check_issue(mk(3'b010, 32'h300, 32'h1111, 1'b1), "ovf_kept_fields");
        answer(1, 32'h0, "ovf_resp_p1");
    endtask

    task automatic test_timeout();
        do_reset();
        set_req(1, mk(3'b100, 32'h500, 32'h0, 1'b0));
        step(); clear_inputs(); step();
        check_issue(mk(3'b100, 32'h500, 32'h0, 1'b0), "to_issue");
        for (int i = 1; i < TO; i++) begin
            step();
            n_checks++;
            if ({busy, bus.o_p1_resp_DV, timeout} !== 3'b100) begin
                n_fail++; $display("FAIL to_wait%0d: got busy=%b resp=%b to=%b expected 1 0 0", i, busy, bus.o_p1_resp_DV, timeout);
            end
        end
        step();
        n_checks++;
        if ({bus.o_p1_resp_DV, bus.o_p1_resp_data, timeout, busy} !== {1'b1, 32'hDEAD_BEEF, 2'b10}) begin
            n_fail++; $display("FAIL to_abort: got dv=%b data=%h to=%b busy=%b expected 1 deadbeef 1 0",
                               bus.o_p1_resp_DV, bus.o_p1_resp_data, timeout, busy);
        end
        step();
        n_checks++;
        if (timeout !== 1'b0) begin
            n_fail++; $display("FAIL to_pulse: got %b expected 0", timeout);
        end
        set_mem(32'h7777_7777);
        step(); clear_inputs();
        n_checks++;
        if ({bus.o_p0_resp_DV, bus.o_p1_resp_DV, bus.o_p1_resp_data} !== {2'b00, 32'hDEAD_BEEF}) begin
            n_fail++; $display("FAIL to_late_ignored: got dv=%b/%b data=%h expected 0/0 deadbeef",
                               bus.o_p0_resp_DV, bus.o_p1_resp_DV, bus.o_p1_resp_data);
        end
    endtask

    task automatic test_boundary();
        do_reset();
        set_req(0, mk(3'b100, 32'h600, 32'h0, 1'b0));
        step(); clear_inputs(); step();
        check_issue(mk(3'b100, 32'h600, 32'h0, 1'b0), "bnd_issue");
        repeat (TO - 1) step();
        set_mem(32'hCAFE_F00D);
        step(); clear_inputs();
        n_checks++;
        if ({bus.o_p0_resp_DV, bus.o_p0_resp_data, timeout} !== {1'b1, 32'hCAFE_F00D, 1'b0}) begin
            n_fail++; $display("FAIL bnd_last_cycle: got dv=%b data=%h to=%b expected 1 cafef00d 0",
                               bus.o_p0_resp_DV, bus.o_p0_resp_data, timeout);
        end
        set_req(0, mk(3'b100, 32'h700, 32'h0, 1'b0));
        step();
        set_req(0, mk(3'b010, 32'h704, 32'h5, 1'b1));
        step(); clear_inputs();
        check_issue(mk(3'b100, 32'h700, 32'h0, 1'b0), "bnd_grant_a");
        n_checks++;
        if (bus.o_p0_overflow !== 1'b0) begin
            n_fail++; $display("FAIL bnd_refill_ovf: got %b expected 0", bus.o_p0_overflow);
        end
        answer(0, 32'h0707_0707, "bnd_resp_a");
        step();
        check_issue(mk(3'b010, 32'h704, 32'h5, 1'b1), "bnd_grant_b");
        answer(0, 32'h0, "bnd_resp_b");
    endtask

    task automatic test_reset_mid_wait();
        int pulses;
        do_reset();
        set_req(1, mk(3'b100, 32'h800, 32'h0, 1'b0));
        step(); clear_inputs(); step(); step();
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({busy, state_dbg, bus.o_mem_DV, mem_obs()} !== '0) begin
            n_fail++; $display("FAIL rst_async: got busy=%b st=%b req=%h expected all zero", busy, state_dbg, mem_obs());
        end
        @(negedge clk); rst_n = 1'b1;
        set_mem(32'h9999_9999);
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            step(); clear_inputs();
            pulses += int'(bus.o_p0_resp_DV) + int'(bus.o_p1_resp_DV) + int'(timeout) + int'(busy);
        end
        n_checks++;
        if (pulses !== 0) begin
            n_fail++; $display("FAIL rst_no_resp: got %0d activity cycles expected 0", pulses);
        end
        set_req(1, mk(3'b100, 32'h900, 32'h0, 1'b0));
        step(); clear_inputs(); step();
        check_issue(mk(3'b100, 32'h900, 32'h0, 1'b0), "rst_next_grant");
        answer(1, 32'h1, "rst_next_resp");
    endtask

    task automatic test_random();
        req_t        pend_req [2];
        bit          pend [2];
        req_t        drv_req [2];
        bit          drv_v [2];
        bit          m_busy, m_owner, m_last, drv_mem, exp_mdv, exp_to;
        int          age, lat, win;
        logic [31:0] drv_mem_data, exp_rdata, obs_rdata;
        req_t        exp_req;
        logic [1:0]  exp_rdv, exp_ovf;
        logic [2:0]  sizes [3];
        sizes = '{3'b001, 3'b010, 3'b100};
        do_reset();
        m_busy = 0; m_owner = 0; m_last = 1; age = 0; lat = 0; drv_mem = 0; drv_mem_data = '0;
        pend = '{0, 0}; drv_v = '{0, 0};
        for (int cyc = 0; cyc < 3000; cyc++) begin
            step();
            exp_mdv = 0; exp_to = 0; exp_rdv = '0; exp_ovf = '0; exp_rdata = '0; exp_req = '0;
            if (!m_busy) begin
                if (pend[0] || pend[1]) begin
                    win = (pend[0] && pend[1]) ? (m_last ? 0 : 1) : (pend[1] ? 1 : 0);
                    exp_mdv = 1; exp_req = pend_req[win]; pend[win] = 0;
                    m_busy = 1; m_owner = win[0]; age = 0; lat = $urandom_range(1, 10);
                end
            end else begin
                age++;
                if (drv_mem) begin
                    exp_rdv[m_owner] = 1'b1; exp_rdata = drv_mem_data; m_busy = 0; m_last = m_owner;
                end else if (age == TO) begin
                    exp_rdv[m_owner] = 1'b1; exp_rdata = 32'hDEAD_BEEF; exp_to = 1; m_busy = 0; m_last = m_owner;
                end
            end
            for (int p = 0; p < 2; p++) begin
                if (drv_v[p]) begin
                    if (pend[p]) exp_ovf[p] = 1'b1;
                    else begin pend[p] = 1; pend_req[p] = drv_req[p]; end
                end
            end
            n_checks++;
            if (busy !== m_busy) begin
                n_fail++; $display("FAIL rnd_busy @%0d: got %b expected %b", cyc, busy, m_busy);
            end
            n_checks++;
            if (bus.o_mem_DV !== exp_mdv) begin
                n_fail++; $display("FAIL rnd_mem_dv @%0d: got %b expected %b", cyc, bus.o_mem_DV, exp_mdv);
            end
            if (exp_mdv) begin
                n_checks++;
                if (mem_obs() !== exp_req) begin
                    n_fail++; $display("FAIL rnd_mem_req @%0d: got %h expected %h", cyc, mem_obs(), exp_req);
                end
            end
            n_checks++;
            if ({bus.o_p1_resp_DV, bus.o_p0_resp_DV} !== exp_rdv) begin
                n_fail++; $display("FAIL rnd_resp_dv @%0d: got %b%b expected %b", cyc, bus.o_p1_resp_DV, bus.o_p0_resp_DV, exp_rdv);
            end
            if (exp_rdv != 2'b00) begin
                obs_rdata = exp_rdv[1] ? bus.o_p1_resp_data : bus.o_p0_resp_data;
                n_checks++;
                if (obs_rdata !== exp_rdata) begin
                    n_fail++; $display("FAIL rnd_resp_data @%0d: got %h expected %h", cyc, obs_rdata, exp_rdata);
                end
            end
            n_checks++;
            if (timeout !== exp_to) begin
                n_fail++; $display("FAIL rnd_timeout @%0d: got %b expected %b", cyc, timeout, exp_to);
            end
            n_checks++;
            if ({bus.o_p1_overflow, bus.o_p0_overflow} !== exp_ovf) begin
                n_fail++; $display("FAIL rnd_overflow @%0d: got %b%b expected %b", cyc, bus.o_p1_overflow, bus.o_p0_overflow, exp_ovf);
            end
            clear_inputs();
            for (int p = 0; p < 2; p++) begin
                drv_v[p] = ($urandom_range(0, 3) == 0);
                if (drv_v[p]) begin
                    drv_req[p] = mk(sizes[$urandom_range(0, 2)], $urandom, $urandom, 1'($urandom_range(0, 1)));
                    set_req(p, drv_req[p]);
                end
            end
            drv_mem = m_busy ? (age + 1 == lat) : ($urandom_range(0, 15) == 0);
            drv_mem_data = $urandom;
            if (drv_mem) set_mem(drv_mem_data);
        end
        step(); clear_inputs();
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_simultaneous();
        test_overflow();
        test_timeout();
        test_boundary();
        test_reset_mid_wait();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
